in_service_register: RTL and testbench
======================================

// Module: in_service_register
// PURPOSE
//  8259A-style In-Service Register (ISR). Latches interrupts handed over by the
//  priority resolver as in service; clears them on End-Of-Interrupt (EOI).
//  Sits between the priority resolver (int_no) and the control logic (eoi).
//  Fully nested priority: bit 0 is highest, bit 7 is lowest.
// PARAMETERS
//  NUM_IRQ  8  number of interrupt lines; fixed at 8 for 8259A compatibility
// PORTS
//  clk      in   1  single system clock; all state updates on rising edge
//  rst_n    in   1  synchronous, active-low reset, sampled on clk rising edge
//  eoi      in   1  non-specific EOI request; acts on its 0->1 transition
//  int_no   in   8  interrupt(s) entering service; per-bit, acts on each 0->1 transition
//  isr      out  8  in-service register contents, registered
//  isr_any  out  1  OR of isr, registered-derived (combinational from isr)
//  isr_top  out  3  index of highest-priority (lowest) set isr bit; 0 when isr==0
// BEHAVIOUR
//  - Reset (rst_n==0 at clk edge): isr=0; eoi_q=0; int_q=0. isr_any=0, isr_top=0.
//  - Edge detect registers: eoi_q<=eoi, int_q<=int_no every cycle (cleared by reset).
//  - set_mask = int_no & ~int_q (newly asserted bits only; held levels do not re-set).
//  - eoi_rise = eoi & ~eoi_q.
//  - clr_mask = one-hot of lowest-index set bit of current isr when eoi_rise, else 0;
//    eoi_rise with isr==0 is a no-op.
//  - Next state: isr <= (isr & ~clr_mask) | set_mask; latency 1 clk from edge to isr.
//  - Simultaneous set+EOI same cycle: clear evaluated on OLD isr, then set applied;
//    a bit both cleared and newly set ends set.
//  - Multiple int_no bits rising together: all set (no arbitration here).
//  - Re-setting an already-set bit: no change. Holding eoi high clears only one bit.
//  - int_q after reset is 0: an int_no bit held high through reset sets on first active cycle.
//  - No X propagation: all registers reset; outputs defined every cycle.
// CONFIGURATION
//  ISR_SPECIFIC_EOI_EN:
//   defined  -> adds inputs eoi_spec (1b) and eoi_level (3b). On eoi_rise with
//               eoi_spec==1, clr_mask = 1<<eoi_level (clears that bit only, even if
//               not highest priority); eoi_spec==0 keeps non-specific behaviour.
//   undefined-> ports absent; only non-specific EOI as above.
// STRUCTURE
//  - Package pic_pkg: NUM_IRQ=8, IRQ_IDX_W=3, typedef irq_vec_t (logic [7:0]),
//    typedef irq_idx_t (logic [2:0]).
//  - Sub-module pic_prio_enc: combinational lowest-index-first encoder over irq_vec_t,
//    outputs valid, idx, onehot; used for clr_mask and isr_top.
// TESTING
//  1 Reset: rst_n=0 two clks with int_no=8'h04 -> isr=00000000, isr_any=0; release -> isr=00000100 after 1 clk.
//  2 Set: int_no 00000000->00000100 -> isr=00000100, isr_top=2; hold int_no 5 clks -> unchanged.
//  3 EOI: isr=00000100, int_no held 00000100, eoi 0->1 -> isr=00000000; eoi held high -> stays 0.
//  4 Nesting: eoi=0, int_no=00001000 then 00000010 -> isr=00001010, isr_top=1; eoi rise
//    -> isr=00001000; second eoi rise -> isr=00000000.
//  5 Simultaneous: isr=00000100, same cycle eoi rise and int_no rise bit 0 -> isr=00000001.
//  6 With ISR_SPECIFIC_EOI_EN: isr=00001010, eoi_spec=1, eoi_level=3, eoi rise -> isr=00000010;
//    eoi rise with isr==0 -> isr stays 0.

Source files
------------

// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pic_pkg
//  Description : Shared types and constants for the 8259A-style interrupt
//                controller slice (in-service register and its encoder).
//                Provides the IRQ vector / index types and a small helper
//                that turns an IRQ index into a one-hot vector.
//  Contents    : NUM_IRQ, IRQ_IDX_W, irq_vec_t, irq_idx_t, idx_to_onehot()
//  Revision    : 1.0  initial release
// ============================================================================
package pic_pkg;

  // Eight lines, fixed for 8259A compatibility.
  localparam int NUM_IRQ   = 8;
  localparam int IRQ_IDX_W = 3;

  typedef logic [NUM_IRQ-1:0]   irq_vec_t;
  typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

  // One-hot vector with only bit <idx> set.
  function automatic irq_vec_t idx_to_onehot(input irq_idx_t idx);
    irq_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage : pic_pkg
`default_nettype wire

// File: rtl/in_service_register_if.sv
`default_nettype none
// ============================================================================
//  Module      : in_service_register_if
//  Description : Signal bundle between the control logic / priority resolver
//                (master) and the in-service register (slave).
//  Signals     : eoi        master->slave  non-specific EOI request (edge)
//                int_no[8]  master->slave  interrupts entering service (edges)
//                eoi_spec   master->slave  specific-EOI select   (optional)
//                eoi_level  master->slave  specific-EOI IRQ index (optional)
//                isr[8]     slave->master  in-service register contents
//                isr_any    slave->master  OR of isr
//                isr_top[3] slave->master  highest-priority in-service index
//  Config      : ISR_SPECIFIC_EOI_EN adds eoi_spec / eoi_level.
//  Revision    : 1.0  initial release
// ============================================================================
interface in_service_register_if;
  import pic_pkg::*;

  logic     eoi;
  irq_vec_t int_no;
`ifdef ISR_SPECIFIC_EOI_EN
  logic     eoi_spec;
  irq_idx_t eoi_level;
`endif
  irq_vec_t isr;
  logic     isr_any;
  irq_idx_t isr_top;

  // Drives requests, observes the register.
  modport master (
    output eoi,
    output int_no,
`ifdef ISR_SPECIFIC_EOI_EN
    output eoi_spec,
    output eoi_level,
`endif
    input  isr,
    input  isr_any,
    input  isr_top
  );

  // The in-service register itself.
  modport slave (
    input  eoi,
    input  int_no,
`ifdef ISR_SPECIFIC_EOI_EN
    input  eoi_spec,
    input  eoi_level,
`endif
    output isr,
    output isr_any,
    output isr_top
  );

endinterface : in_service_register_if
`default_nettype wire

// File: rtl/pic_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : pic_prio_enc
//  Description : Combinational lowest-index-first priority encoder. Bit 0 is
//                the highest priority. Used to pick the bit cleared by a
//                non-specific EOI and to report the top in-service level.
//  Ports       : vec_i    in   irq_vec_t  request vector
//                valid_o  out  1          any bit of vec_i set
//                idx_o    out  irq_idx_t  index of lowest set bit (0 if none)
//                onehot_o out  irq_vec_t  one-hot of lowest set bit (0 if none)
//  Revision    : 1.0  initial release
// ============================================================================
module pic_prio_enc
  import pic_pkg::*;
(
  input  irq_vec_t vec_i,
  output logic     valid_o,
  output irq_idx_t idx_o,
  output irq_vec_t onehot_o
);

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    // Walk from the lowest priority down to the highest so that the last
    // match, i.e. the lowest set index, is what remains.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        valid_o  = 1'b1;
        idx_o    = irq_idx_t'(i);
        onehot_o = idx_to_onehot(irq_idx_t'(i));
      end
    end
  end

endmodule : pic_prio_enc
`default_nettype wire

// File: rtl/in_service_register.sv
`default_nettype none
// ============================================================================
//  Module      : in_service_register
//  Description : 8259A-style In-Service Register. Bits are set on the rising
//                edge of the corresponding int_no line and cleared by an EOI
//                rising edge (lowest set index first - fully nested mode).
//                A clear and a set in the same cycle: clear acts on the old
//                contents, then the set is applied, so a bit both cleared and
//                newly set ends set.
//  Ports       : clk      in   1  system clock, rising edge
//                rst_n    in   1  synchronous active-low reset
//                bus      slave modport of in_service_register_if
//                         (eoi, int_no, [eoi_spec, eoi_level] in;
//                          isr, isr_any, isr_top out)
//  Config      : ISR_SPECIFIC_EOI_EN - when defined, an EOI edge with
//                eoi_spec==1 clears bit eoi_level instead of the top bit.
//  Revision    : 1.0  initial release
// ============================================================================
module in_service_register
  import pic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  in_service_register_if.slave    bus
);

  // Edge-detect history and the register itself.
  logic     eoi_q, eoi_d;
  irq_vec_t int_q, int_d;
  irq_vec_t isr_q, isr_d;

  logic     eoi_rise;
  irq_vec_t set_mask;
  irq_vec_t clr_mask;

  logic     enc_valid;
  irq_idx_t enc_idx;
  irq_vec_t enc_onehot;

  // Encoder looks at the current (old) register contents, which gives the
  // required clear-before-set ordering for same-cycle events.
  pic_prio_enc u_prio_enc (
    .vec_i    (isr_q),
    .valid_o  (enc_valid),
    .idx_o    (enc_idx),
    .onehot_o (enc_onehot)
  );

  always_comb begin
    eoi_d    = bus.eoi;
    int_d    = bus.int_no;

    // Only newly asserted lines enter service; held levels do nothing.
    set_mask = bus.int_no & ~int_q;
    eoi_rise = bus.eoi & ~eoi_q;

    clr_mask = '0;
    if (eoi_rise) begin
`ifdef ISR_SPECIFIC_EOI_EN
      if (bus.eoi_spec) begin
        clr_mask = idx_to_onehot(bus.eoi_level);
      end else if (enc_valid) begin
        clr_mask = enc_onehot;
      end
`else
      // An EOI with nothing in service is a no-op.
      if (enc_valid) begin
        clr_mask = enc_onehot;
      end
`endif
    end

    isr_d = (isr_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eoi_q <= 1'b0;
      int_q <= '0;
      isr_q <= '0;
    end else begin
      eoi_q <= eoi_d;
      int_q <= int_d;
      isr_q <= isr_d;
    end
  end

  // isr_any / isr_top are derived purely from the registered contents.
  assign bus.isr     = isr_q;
  assign bus.isr_any = enc_valid;
  assign bus.isr_top = enc_idx;

endmodule : in_service_register
`default_nettype wire

// File: tb/tb_in_service_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_in_service_register
//  Description : Self-checking bench for in_service_register. Directed
//                scenarios followed by a randomized run compared against a
//                cycle-level behavioural model of the ISR rules.
//  Config      : ISR_SPECIFIC_EOI_EN enables the specific-EOI scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_in_service_register;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  // Behavioural model state.
  logic [7:0] m_isr;
  logic [7:0] m_int;
  logic       m_eoi;

  in_service_register_if bus ();

  in_service_register dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Highest-priority (lowest-index) set bit as a one-hot value.
  function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Advance one clock: update the model from the inputs currently applied,
  // then let the DUT take the edge and sample #1 later.
  task automatic step();
    logic [7:0] clr;
    if (!rst_n) begin
      m_isr = '0;
      m_int = '0;
      m_eoi = 1'b0;
    end else begin
      clr = '0;
      if (bus.eoi && !m_eoi) begin
`ifdef ISR_SPECIFIC_EOI_EN
        if (bus.eoi_spec) clr = 8'd1 << bus.eoi_level;
        else
`endif
        clr = lowest_onehot(m_isr);
      end
      m_isr = (m_isr & ~clr) | (bus.int_no & ~m_int);
      m_int = bus.int_no;
      m_eoi = bus.eoi;
    end
    @(posedge clk);
    #1;
  endtask

  // Bring the register back to empty from any state.
  task automatic drain();
    bus.int_no = 8'h00;
    for (int k = 0; k < 9; k++) begin
      bus.eoi = 1'b1; step();
      bus.eoi = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.int_no = 8'h04;
    step(); step();
    checks++;
    if (bus.isr !== 8'h00) begin
      errors++; $display("FAIL reset_isr: got %b want 00000000", bus.isr);
    end
    checks++;
    if (bus.isr_any !== 1'b0 || bus.isr_top !== 3'd0) begin
      errors++; $display("FAIL reset_flags: got any=%b top=%0d want any=0 top=0", bus.isr_any, bus.isr_top);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.isr !== 8'h04) begin
      errors++; $display("FAIL reset_release: got %b want 00000100", bus.isr);
    end
  endtask

  task automatic test_set();
    drain();
    bus.int_no = 8'h04;
    step();
    checks++;
    if (bus.isr !== 8'h04 || bus.isr_top !== 3'd2 || bus.isr_any !== 1'b1) begin
      errors++; $display("FAIL set: got isr=%b top=%0d any=%b want 00000100 2 1", bus.isr, bus.isr_top, bus.isr_any);
    end
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (bus.isr !== 8'h04) begin
      errors++; $display("FAIL set_hold: got %b want 00000100", bus.isr);
    end
  endtask

  task automatic test_eoi();
    // int_no still held at 04 with isr=04.
    bus.eoi = 1'b1;
    step();
    checks++;
    if (bus.isr !== 8'h00 || bus.isr_any !== 1'b0) begin
      errors++; $display("FAIL eoi_clear: got isr=%b any=%b want 00000000 0", bus.isr, bus.isr_any);
    end
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (bus.isr !== 8'h00) begin
      errors++; $display("FAIL eoi_held: got %b want 00000000", bus.isr);
    end
    bus.eoi = 1'b0;
    step();
  endtask

  task automatic test_nesting();
    drain();
    bus.int_no = 8'h08; step();
    bus.int_no = 8'h02; step();
    checks++;
    if (bus.isr !== 8'h0A || bus.isr_top !== 3'd1) begin
      errors++; $display("FAIL nest_set: got isr=%b top=%0d want 00001010 1", bus.isr, bus.isr_top);
    end
    bus.eoi = 1'b1; step();
    checks++;
    if (bus.isr !== 8'h08 || bus.isr_top !== 3'd3) begin
      errors++; $display("FAIL nest_eoi1: got isr=%b top=%0d want 00001000 3", bus.isr, bus.isr_top);
    end
    bus.eoi = 1'b0; step();
    bus.eoi = 1'b1; step();
    checks++;
    if (bus.isr !== 8'h00) begin
      errors++; $display("FAIL nest_eoi2: got %b want 00000000", bus.isr);
    end
    bus.eoi = 1'b0; step();
  endtask

  task automatic test_simultaneous();
    drain();
    bus.int_no = 8'h04; step();
    bus.int_no = 8'h05; bus.eoi = 1'b1; step();
    checks++;
    if (bus.isr !== 8'h01) begin
      errors++; $display("FAIL simul: got %b want 00000001", bus.isr);
    end
    // Same bit cleared and newly set in one cycle ends set.
    bus.int_no = 8'h00; bus.eoi = 1'b0; step();
    bus.int_no = 8'h01; bus.eoi = 1'b1; step();
    checks++;
    if (bus.isr !== 8'h01) begin
      errors++; $display("FAIL simul_same_bit: got %b want 00000001", bus.isr);
    end
    // Multiple lines rising together all enter service.
    bus.int_no = 8'hA1; bus.eoi = 1'b0; step();
    checks++;
    if (bus.isr !== 8'hA1 || bus.isr_top !== 3'd0) begin
      errors++; $display("FAIL multi_set: got isr=%b top=%0d want 10100001 0", bus.isr, bus.isr_top);
    end
  endtask

`ifdef ISR_SPECIFIC_EOI_EN
  task automatic test_specific_eoi();
    drain();
    bus.int_no = 8'h08; step();
    bus.int_no = 8'h02; step();
    bus.eoi_spec = 1'b1; bus.eoi_level = 3'd3; bus.eoi = 1'b1; step();
    checks++;
    if (bus.isr !== 8'h02) begin
      errors++; $display("FAIL spec_eoi: got %b want 00000010", bus.isr);
    end
    bus.eoi = 1'b0; step();
    bus.eoi_level = 3'd1; bus.eoi = 1'b1; step();
    bus.eoi = 1'b0; step();
    bus.eoi = 1'b1; step();
    checks++;
    if (bus.isr !== 8'h00) begin
      errors++; $display("FAIL spec_eoi_empty: got %b want 00000000", bus.isr);
    end
    bus.eoi = 1'b0; bus.eoi_spec = 1'b0; bus.eoi_level = 3'd0; step();
  endtask
`endif

  task automatic test_random();
    // Resync the model with a reset before free-running.
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      bus.int_no = 8'($urandom) & 8'($urandom);
      bus.eoi    = ($urandom_range(0, 2) == 0);
`ifdef ISR_SPECIFIC_EOI_EN
      bus.eoi_spec  = $urandom_range(0, 1) == 1;
      bus.eoi_level = 3'($urandom_range(0, 7));
`endif
      rst_n = ($urandom_range(0, 49) != 0);
      step();
      checks++;
      if (bus.isr !== m_isr) begin
        errors++; $display("FAIL rand_isr[%0d]: got %b want %b", n, bus.isr, m_isr);
      end
      checks++;
      if (bus.isr_any !== (m_isr != 8'h00)) begin
        errors++; $display("FAIL rand_any[%0d]: got %b want %b", n, bus.isr_any, (m_isr != 8'h00));
      end
      checks++;
      if (bus.isr_top !== lowest_index(m_isr)) begin
        errors++; $display("FAIL rand_top[%0d]: got %0d want %0d", n, bus.isr_top, lowest_index(m_isr));
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.eoi = 1'b0;
    bus.int_no = 8'h00;
`ifdef ISR_SPECIFIC_EOI_EN
    bus.eoi_spec = 1'b0;
    bus.eoi_level = 3'd0;
`endif
    m_isr = '0; m_int = '0; m_eoi = 1'b0;
    @(posedge clk); #1;

    test_reset();
    test_set();
    test_eoi();
    test_nesting();
    test_simultaneous();
`ifdef ISR_SPECIFIC_EOI_EN
    test_specific_eoi();
`endif
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_in_service_register
`default_nettype wire
